// File: rtl/pll_rst_seq_pkg.sv
// Shared types and defaults for the pixel-clock PLL reset/lock sequencer.
// The relock counter is only built when PLL_RST_SEQ_RELOCK_CNT_EN is defined.
package pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

  localparam int DEF_RST_HOLD_CYC     = 16;
  localparam int DEF_LOCK_TIMEOUT_CYC = 125000;
  localparam int DEF_STABLE_CYC       = 1024;
  localparam int DEF_MAX_RETRIES      = 3;

  localparam int RELOCK_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pll_rst_seq_sync_2ff.sv
// Generic two-flop synchroniser with asynchronous active-high reset.
// Shared by every block that brings a signal into a new clock domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset/lock sequencer: pulses PLL reset, waits for lock with timeout and retries,
// qualifies lock over a stability window, then releases the system reset.
// Optional relock counter: define PLL_RST_SEQ_RELOCK_CNT_EN.
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int RST_HOLD_CYC     = DEF_RST_HOLD_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int STABLE_CYC       = DEF_STABLE_CYC,
  parameter int MAX_RETRIES      = DEF_MAX_RETRIES
) (
  input  logic                i_clk_125MHz,
  input  logic                i_rst,
  input  logic                i_locked,
  output logic                o_pll_rst,
  output logic                o_sys_rst,
  output logic                o_ready,
  output logic                o_fault,
  output logic [RELOCK_W-1:0] o_relock_cnt,
  output state_t              o_state
);

  localparam int CNT_MAX = max3(RST_HOLD_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RTY_W   = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT    = RTY_W'(MAX_RETRIES);

  logic             locked_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [RTY_W-1:0] retry;
  logic [RTY_W-1:0] retry_nxt;

  sync_2ff #(
    .WIDTH(1)
  ) u_lock_sync (
    .clk(i_clk_125MHz),
    .rst(i_rst),
    .d  (i_locked),
    .q  (locked_s)
  );

  // Lock wins over timeout in WAIT_LOCK; lock loss wins over terminal count in STABLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    retry_nxt = retry;
    case (state)
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          retry_nxt = retry + RTY_W'(1);
          state_nxt = (retry_nxt == RTY_LIMIT) ? FAULT : HOLD;
          cnt_nxt   = '0;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = RUN;
          retry_nxt = '0;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (!locked_s) state_nxt = HOLD;
      end
      FAULT: begin
        cnt_nxt = '0;
      end
      default: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge i_clk_125MHz or posedge i_rst) begin
    if (i_rst) begin
      state     <= HOLD;
      cnt       <= '0;
      retry     <= '0;
      o_pll_rst <= 1'b1;
      o_sys_rst <= 1'b1;
      o_ready   <= 1'b0;
      o_fault   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry     <= retry_nxt;
      o_pll_rst <= (state_nxt == HOLD) || (state_nxt == FAULT);
      o_sys_rst <= (state_nxt != RUN);
      o_ready   <= (state_nxt == RUN);
      o_fault   <= (state_nxt == FAULT);
    end
  end

  assign o_state = state;

`ifdef PLL_RST_SEQ_RELOCK_CNT_EN
  logic                relock_inc;
  logic [RELOCK_W-1:0] relock_cnt;

  assign relock_inc = (state == RUN) && !locked_s;

  always_ff @(posedge i_clk_125MHz or posedge i_rst) begin
    if (i_rst) begin
      relock_cnt <= '0;
    end else if (relock_inc && (relock_cnt != {RELOCK_W{1'b1}})) begin
      relock_cnt <= relock_cnt + RELOCK_W'(1);
    end
  end

  assign o_relock_cnt = relock_cnt;
`else
  assign o_relock_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq: a default-parameter instance for the
// absolute edge timings and a shortened instance checked against a reference model.
module tb_pll_rst_seq;
  import pll_rst_seq_pkg::*;

  localparam int T_HOLD = 4;
  localparam int T_TO   = 40;
  localparam int T_ST   = 32;
  localparam int T_RTY  = 3;

  // clock / reset
  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic       rst;
  logic       locked;
  logic       locked_def;
  logic       pll_rst, sys_rst, ready, fault;
  logic [7:0] relock_cnt;
  state_t     state;
  logic       d_pll_rst, d_sys_rst, d_ready, d_fault;
  logic [7:0] d_relock_cnt;
  state_t     d_state;

  pll_rst_seq #(
    .RST_HOLD_CYC    (T_HOLD),
    .LOCK_TIMEOUT_CYC(T_TO),
    .STABLE_CYC      (T_ST),
    .MAX_RETRIES     (T_RTY)
  ) dut (
    .i_clk_125MHz(clk),
    .i_rst       (rst),
    .i_locked    (locked),
    .o_pll_rst   (pll_rst),
    .o_sys_rst   (sys_rst),
    .o_ready     (ready),
    .o_fault     (fault),
    .o_relock_cnt(relock_cnt),
    .o_state     (state)
  );

  pll_rst_seq dut_def (
    .i_clk_125MHz(clk),
    .i_rst       (rst),
    .i_locked    (locked_def),
    .o_pll_rst   (d_pll_rst),
    .o_sys_rst   (d_sys_rst),
    .o_ready     (d_ready),
    .o_fault     (d_fault),
    .o_relock_cnt(d_relock_cnt),
    .o_state     (d_state)
  );

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: phase plus the edge index at which it was entered
  state_t m_st;
  int     m_now;
  int     m_entered;
  int     m_rty;
  int     m_relock;
  bit     m_s1, m_s2;

  task automatic model_reset();
    m_st      = HOLD;
    m_now     = 0;
    m_entered = 0;
    m_rty     = 0;
    m_relock  = 0;
    m_s1      = 1'b0;
    m_s2      = 1'b0;
  endtask

  task automatic go(input state_t s);
    m_st      = s;
    m_entered = m_now;
  endtask

  task automatic model_step(input bit lk);
    bit sl;
    int k;
    sl    = m_s2;
    m_s2  = m_s1;
    m_s1  = lk;
    m_now = m_now + 1;
    k     = m_now - m_entered;
    case (m_st)
      HOLD:      if (k == T_HOLD) go(WAIT_LOCK);
      WAIT_LOCK: begin
        if (sl) go(STABLE);
        else if (k == T_TO) begin
          m_rty = m_rty + 1;
          go((m_rty == T_RTY) ? FAULT : HOLD);
        end
      end
      STABLE: begin
        if (!sl) go(HOLD);
        else if (k == T_ST) begin
          m_rty = 0;
          go(RUN);
        end
      end
      RUN: begin
        if (!sl) begin
          if (m_relock < 255) m_relock = m_relock + 1;
          go(HOLD);
        end
      end
      default: ;
    endcase
  endtask

  function automatic int exp_relock();
`ifdef PLL_RST_SEQ_RELOCK_CNT_EN
    return m_relock;
`else
    return 0;
`endif
  endfunction

  task automatic compare_all();
    check("state",      32'(state),      32'(m_st));
    check("pll_rst",    32'(pll_rst),    32'((m_st == HOLD) || (m_st == FAULT)));
    check("sys_rst",    32'(sys_rst),    32'(m_st != RUN));
    check("ready",      32'(ready),      32'(m_st == RUN));
    check("fault",      32'(fault),      32'(m_st == FAULT));
    check("relock_cnt", 32'(relock_cnt), 32'(exp_relock()));
  endtask

  // driver: inputs change on the falling edge, outputs checked on the next falling edge
  task automatic cyc(input bit lk, input bit r);
    locked = lk;
    rst    = r;
    if (r) begin
      model_reset();
      #1;
      compare_all();
    end
    @(posedge clk);
    if (!r) model_step(lk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_run();
    for (int i = 0; i < 300; i++) begin
      if (m_st == RUN) return;
      cyc(1'b1, 1'b0);
    end
    check("run_reached", 32'(ready), 32'd1);
  endtask

  task automatic wait_stable_mid();
    for (int i = 0; i < 300; i++) begin
      if ((m_st == STABLE) && (m_now - m_entered >= T_ST / 2)) return;
      cyc(1'b1, 1'b0);
    end
    check("stable_reached", 32'(state), 32'(STABLE));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    locked     = 1'b0;
    locked_def = 1'b1;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);

    // lock held from reset release: absolute edge timing on the default instance
    for (int e = 1; e <= 1045; e++) begin
      cyc(1'b1, 1'b0);
      if (e == 15)   check("def_pll_rst_e15", 32'(d_pll_rst), 32'd1);
      if (e == 16)   check("def_pll_rst_e16", 32'(d_pll_rst), 32'd0);
      if (e == 1040) begin
        check("def_ready_e1040",   32'(d_ready),   32'd0);
        check("def_sys_rst_e1040", 32'(d_sys_rst), 32'd1);
      end
      if (e == 1041) begin
        check("def_ready_e1041",   32'(d_ready),   32'd1);
        check("def_sys_rst_e1041", 32'(d_sys_rst), 32'd0);
        check("def_fault_e1041",   32'(d_fault),   32'd0);
      end
    end

    // no lock ever: three attempts then sticky fault
    cyc(1'b0, 1'b1);
    for (int i = 0; i < T_RTY * (T_HOLD + T_TO) + 20; i++) cyc(1'b0, 1'b0);
    check("fault_latched", 32'(fault), 32'd1);
    for (int i = 0; i < 40; i++) cyc(1'($urandom_range(0, 1)), 1'b0);
    check("fault_sticky", 32'(fault), 32'd1);

    // reset pulse in FAULT, then again mid-WAIT_LOCK
    cyc(1'b0, 1'b1);
    for (int i = 0; i < T_HOLD + 6; i++) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    wait_run();

    // short lock loss in RUN
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    wait_run();

    // lock loss midway through STABLE
    cyc(1'b1, 1'b1);
    wait_stable_mid();
    cyc(1'b0, 1'b0);
    wait_run();

    // two timeouts, lock on the third attempt, then many lock losses in RUN
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 2 * (T_HOLD + T_TO); i++) cyc(1'b0, 1'b0);
    wait_run();
    for (int n = 0; n < 300; n++) begin
      int drop;
      drop = $urandom_range(1, 3);
      for (int i = 0; i < drop; i++) cyc(1'b0, 1'b0);
      wait_run();
    end
    check("no_fault_after_relocks", 32'(fault), 32'd0);
`ifdef PLL_RST_SEQ_RELOCK_CNT_EN
    check("relock_saturated", 32'(relock_cnt), 32'd255);
`else
    check("relock_tied_off", 32'(relock_cnt), 32'd0);
`endif

    // random lock bursts with occasional reset
    for (int seg = 0; seg < 150; seg++) begin
      bit lk;
      int len;
      lk  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 60);
      for (int i = 0; i < len; i++) cyc(lk, ($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
